// File: rtl/mem_burst_responder_pkg.sv
// Shared definitions for the memory-bus burst responder: access-size codes,
// default base address, FSM states and burst-length helpers.
package mem_burst_responder_pkg;

  localparam logic [1:0] ACC_1W  = 2'b00;
  localparam logic [1:0] ACC_4W  = 2'b01;
  localparam logic [1:0] ACC_8W  = 2'b10;
  localparam logic [1:0] ACC_16W = 2'b11;

  localparam logic [31:0] DEF_BASE_ADDR = 32'h8002_0000;

  typedef enum logic [1:0] {StIdle, StWrite, StRead, StRdrain} state_e;

  function automatic logic [4:0] burst_len(input logic [1:0] acc);
    unique case (acc)
      ACC_1W:  return 5'd1;
      ACC_4W:  return 5'd4;
      ACC_8W:  return 5'd8;
      default: return 5'd16;
    endcase
  endfunction

  // Index of the final beat (N-1), the form the beat counter compares against.
  function automatic logic [3:0] last_beat(input logic [1:0] acc);
    logic [4:0] len;
    len = burst_len(acc) - 5'd1;
    return len[3:0];
  endfunction

endpackage

// File: rtl/mem_burst_responder_if.sv
// Processor memory bus between an initiator (fetch, load/store, loader) and
// the burst responder.
interface mem_burst_responder_if;
  logic        enable;
  logic [31:0] addr;
  logic [31:0] data_in;
  logic        wren;
  logic [1:0]  acc_size;
  logic [31:0] data_out;
  logic        busy;
  logic        err;

  modport master (
    output enable, addr, data_in, wren, acc_size,
    input  data_out, busy, err
  );

  modport slave (
    input  enable, addr, data_in, wren, acc_size,
    output data_out, busy, err
  );
endinterface

// File: rtl/mem_burst_addr_gen.sv
// Burst address generator: loads start word and last-beat index, steps the
// beat counter and RAM word address, and flags the final beat.
module mem_burst_addr_gen #(
  parameter int unsigned RAM_AW = 18
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  logic [RAM_AW-1:0] start_word,
  input  logic [3:0]        beat_max,
  output logic [RAM_AW-1:0] word_addr,
  output logic              last
);

  logic [RAM_AW-1:0] addr_q;
  logic [3:0]        beat_q;
  logic [3:0]        max_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q <= '0;
      beat_q <= '0;
      max_q  <= '0;
    end else if (load) begin
      addr_q <= start_word;
      beat_q <= 4'd0;
      max_q  <= beat_max;
    end else if (step) begin
      addr_q <= addr_q + RAM_AW'(1);
      beat_q <= beat_q + 4'd1;
    end
  end

  assign word_addr = addr_q;
  assign last      = (beat_q == max_q);

endmodule

// File: rtl/mem_burst_responder.sv
// Memory-bus burst responder: decodes and range-checks commands, then drives
// one word per cycle onto an external single-port synchronous RAM.
module mem_burst_responder
  import mem_burst_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter int unsigned RAM_AW    = 18
) (
  input  logic                    clock,
  input  logic                    reset,
  mem_burst_responder_if.slave    bus,
  output logic                    ram_en,
  output logic                    ram_we,
  output logic [RAM_AW-1:0]       ram_addr,
  output logic [31:0]             ram_wdata,
  input  logic [31:0]             ram_rdata
);

  state_e      state_q, state_d;
  logic        en_q, en_d, we_q, we_d;
  logic        err_q, err_d;
  logic        rd_pend_q, rd_pend_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] dout_q, dout_d;

  logic [31:0] cmd_word, cmd_end;
  logic [3:0]  cmd_last;
  logic        cmd_bad;
  logic        abort;
  logic        gen_load, gen_step, gen_last;

  // The whole burst is range-checked up front so the address counter never wraps.
  always_comb begin
    cmd_last = last_beat(bus.acc_size);
    cmd_word = (bus.addr - BASE_ADDR) >> 2;
    cmd_end  = cmd_word + {28'd0, cmd_last};
    cmd_bad  = (bus.addr[1:0] != 2'b00) || (bus.addr < BASE_ADDR) ||
               ((cmd_end >> RAM_AW) != 32'd0);
  end

  mem_burst_addr_gen #(
    .RAM_AW (RAM_AW)
  ) u_addr_gen (
    .clock      (clock),
    .reset      (reset),
    .load       (gen_load),
    .step       (gen_step),
    .start_word (cmd_word[RAM_AW-1:0]),
    .beat_max   (cmd_last),
    .word_addr  (ram_addr),
    .last       (gen_last)
  );

  always_comb begin
    state_d  = state_q;
    en_d     = 1'b0;
    we_d     = 1'b0;
    err_d    = 1'b0;
    wdata_d  = wdata_q;
    gen_load = 1'b0;
    gen_step = 1'b0;
    abort    = (state_q != StIdle) && !bus.enable;

    unique case (state_q)
      StIdle: begin
        if (bus.enable) begin
          if (cmd_bad) begin
            err_d = 1'b1;
          end else begin
            gen_load = 1'b1;
            en_d     = 1'b1;
            we_d     = bus.wren;
            if (bus.wren) begin
              wdata_d = bus.data_in;
              // A single write completes in the strobe cycle without going busy.
              if (cmd_last != 4'd0) state_d = StWrite;
            end else begin
              state_d = StRead;
            end
          end
        end
      end
      StWrite: begin
        if (abort || gen_last) begin
          state_d = StIdle;
        end else begin
          gen_step = 1'b1;
          en_d     = 1'b1;
          we_d     = 1'b1;
          wdata_d  = bus.data_in;
        end
      end
      StRead: begin
        if (abort) begin
          state_d = StIdle;
        end else if (gen_last) begin
          state_d = StRdrain;
        end else begin
          gen_step = 1'b1;
          en_d     = 1'b1;
        end
      end
      StRdrain: state_d = StIdle;
      default:  state_d = StIdle;
    endcase

    // Read data returns one cycle after the strobe; an abort discards it.
    rd_pend_d = en_q && !we_q && !abort;
    dout_d    = rd_pend_q ? ram_rdata : dout_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      en_q      <= 1'b0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      rd_pend_q <= 1'b0;
      wdata_q   <= '0;
      dout_q    <= '0;
    end else begin
      state_q   <= state_d;
      en_q      <= en_d;
      we_q      <= we_d;
      err_q     <= err_d;
      rd_pend_q <= rd_pend_d;
      wdata_q   <= wdata_d;
      dout_q    <= dout_d;
    end
  end

  assign ram_en       = en_q;
  assign ram_we       = we_q;
  assign ram_wdata    = wdata_q;
  assign bus.data_out = dout_q;
  assign bus.busy     = (state_q != StIdle);
  assign bus.err      = err_q;

endmodule

// File: tb/tb_mem_burst_responder.sv
// Directed bench for mem_burst_responder with a behavioural latency-1 RAM.
module tb_mem_burst_responder;
  import mem_burst_responder_pkg::*;

  localparam int unsigned AW   = 18;
  localparam logic [31:0] BASE = 32'h8002_0000;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata, ram_rdata;

  mem_burst_responder_if bus ();

  mem_burst_responder #(
    .BASE_ADDR (BASE),
    .RAM_AW    (AW)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  always #5 clock = ~clock;

  int            vectors     = 0;
  int            miscompares = 0;
  int            en_count    = 0;
  int            we_bad      = 0;
  logic [31:0]   mem [0:(1<<AW)-1];
  logic [31:0]   rdata_q = '0;
  logic [AW-1:0] wr_log [$];

  assign ram_rdata = rdata_q;

  always @(posedge clock) begin
    if (ram_en) begin
      en_count <= en_count + 1;
      if (ram_we) begin
        mem[ram_addr] <= ram_wdata;
        wr_log.push_back(ram_addr);
      end else begin
        rdata_q <= mem[ram_addr];
      end
    end
    if (ram_we && !ram_en) we_bad <= we_bad + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] pat(input logic [31:0] seed, input int k);
    return seed + 32'(k) * 32'h1111_1111;
  endfunction

  task automatic do_write(input logic [31:0] a, input int n, input logic [1:0] acc,
                          input logic [31:0] seed);
    int w;
    w = int'((a - BASE) >> 2);
    bus.enable = 1'b1; bus.addr = a; bus.wren = 1'b1; bus.acc_size = acc;
    bus.data_in = pat(seed, 0);
    for (int j = 1; j <= n; j++) begin
      tick();
      check("wr_en",   32'(ram_en), 32'd1);
      check("wr_we",   32'(ram_we), 32'd1);
      check("wr_addr", 32'(ram_addr), 32'(w + j - 1));
      check("wr_data", ram_wdata, pat(seed, j - 1));
      check("wr_busy", 32'(bus.busy), (n > 1) ? 32'd1 : 32'd0);
      if (j == 1) begin
        bus.addr = 32'hDEAD_BEEC; bus.wren = 1'b0; bus.acc_size = ~acc;
      end
      bus.data_in = pat(seed, j);
      if (j == n) bus.enable = 1'b0;
    end
    tick();
    check("wr_end_busy", 32'(bus.busy), 32'd0);
    check("wr_end_en",   32'(ram_en), 32'd0);
  endtask

  task automatic do_read(input logic [31:0] a, input int n, input logic [1:0] acc,
                         input logic [31:0] seed);
    int w, busy_cnt;
    w = int'((a - BASE) >> 2);
    busy_cnt = 0;
    bus.enable = 1'b1; bus.addr = a; bus.wren = 1'b0; bus.acc_size = acc;
    for (int j = 1; j <= n + 2; j++) begin
      tick();
      if (bus.busy) busy_cnt++;
      if (j <= n) begin
        check("rd_en",   32'(ram_en), 32'd1);
        check("rd_we",   32'(ram_we), 32'd0);
        check("rd_addr", 32'(ram_addr), 32'(w + j - 1));
      end else begin
        check("rd_drain_en", 32'(ram_en), 32'd0);
      end
      if (j >= 3) check("rd_data", bus.data_out, pat(seed, j - 3));
      if (j == 1) begin
        bus.addr = 32'hDEAD_BEEC; bus.wren = 1'b1; bus.acc_size = ~acc;
      end
      if (j == n + 2) bus.enable = 1'b0;
    end
    check("rd_busy_cycles", 32'(busy_cnt), 32'(n + 1));
    check("rd_end_busy", 32'(bus.busy), 32'd0);
    tick();
    check("rd_hold", bus.data_out, pat(seed, n - 1));
  endtask

  task automatic do_reject(input logic [31:0] a, input logic [1:0] acc, input logic wr);
    int en_before;
    en_before = en_count;
    bus.enable = 1'b1; bus.addr = a; bus.wren = wr; bus.acc_size = acc;
    bus.data_in = 32'h5555_AAAA;
    tick();
    check("rej_err",  32'(bus.err), 32'd1);
    check("rej_en",   32'(ram_en), 32'd0);
    check("rej_busy", 32'(bus.busy), 32'd0);
    bus.enable = 1'b0;
    tick();
    check("rej_err_pulse", 32'(bus.err), 32'd0);
    check("rej_no_access", 32'(en_count), 32'(en_before));
  endtask

  initial begin
    bus.enable = 1'b0; bus.addr = '0; bus.data_in = '0; bus.wren = 1'b0; bus.acc_size = '0;
    reset = 1'b1;
    tick();
    tick();
    check("rst_data_out", bus.data_out, 32'd0);
    check("rst_busy",     32'(bus.busy), 32'd0);
    check("rst_err",      32'(bus.err), 32'd0);
    check("rst_ram_en",   32'(ram_en), 32'd0);
    check("rst_ram_we",   32'(ram_we), 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_wdata",    ram_wdata, 32'd0);
    reset = 1'b0;
    tick();

    do_write(BASE, 1, ACC_1W, 32'h27BD_FFE8);
    do_read(BASE, 1, ACC_1W, 32'h27BD_FFE8);

    do_write(BASE + 32'h4, 4, ACC_4W, 32'hA500_0001);
    do_read(BASE + 32'h4, 4, ACC_4W, 32'hA500_0001);

    do_write(BASE + 32'h20, 16, ACC_16W, 32'h0BAD_F00D);
    do_read(BASE + 32'h20, 16, ACC_16W, 32'h0BAD_F00D);

    do_reject(32'h8000_0000, ACC_1W, 1'b0);
    do_reject(32'h8002_0002, ACC_1W, 1'b1);
    do_reject(32'h8011_FFE0, ACC_16W, 1'b0);

    // Last eight words of the RAM: fits exactly, so it is accepted.
    do_write(32'h8011_FFE0, 8, ACC_8W, 32'h7700_0000);
    do_read(32'h8011_FFE0, 8, ACC_8W, 32'h7700_0000);

    // Abort an 8-word write at word 64 after beat 3.
    wr_log.delete();
    bus.enable = 1'b1; bus.addr = BASE + 32'h100; bus.wren = 1'b1; bus.acc_size = ACC_8W;
    bus.data_in = pat(32'h1234_5678, 0);
    for (int j = 1; j <= 4; j++) begin
      tick();
      bus.data_in = pat(32'h1234_5678, j);
      if (j == 4) bus.enable = 1'b0;
    end
    tick();
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_en",   32'(ram_en), 32'd0);
    tick();
    check("abort_en2",  32'(ram_en), 32'd0);
    check("abort_count", 32'(wr_log.size()), 32'd4);
    for (int i = 0; i < wr_log.size() && i < 4; i++) check("abort_addr", 32'(wr_log[i]), 32'(64 + i));

    // Reset while beat 5 of an 8-word read is on the RAM.
    bus.enable = 1'b1; bus.addr = BASE + 32'h20; bus.wren = 1'b0; bus.acc_size = ACC_8W;
    for (int j = 1; j <= 6; j++) tick();
    check("prerst_addr", 32'(ram_addr), 32'd13);
    check("prerst_data", bus.data_out, pat(32'h0BAD_F00D, 3));
    reset = 1'b1;
    tick();
    check("midrst_data", bus.data_out, 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_en",   32'(ram_en), 32'd0);
    reset = 1'b0;
    bus.enable = 1'b0;
    tick();
    do_read(BASE + 32'h4, 4, ACC_4W, 32'hA500_0001);

    check("we_without_en", 32'(we_bad), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
